// File: rtl/alu_sequencer.sv
// EX-stage execution controller: single-cycle ALU ops plus an
// iterative shift-add multiplier that stalls the pipeline until done.
`ifndef ADD
`define ADD 3'b010
`endif
`ifndef SUB
`define SUB 3'b110
`endif
`ifndef AND
`define AND 3'b000
`endif
`ifndef OR
`define OR 3'b001
`endif
`ifndef MUL
`define MUL 3'b011
`endif

module alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] alu;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             is_mul;

  assign is_mul  = (ALUCtrl_i == `MUL);
  assign accept  = (state == IDLE) && valid_i && !flush_i;
  assign stall_o = (accept && is_mul) || (state == BUSY);
  assign sum     = acc + (mplr[0] ? mcand : '0);

  always_comb begin
    alu = data1_i + data2_i;
    case (ALUCtrl_i)
      `SUB:    alu = data1_i - data2_i;
      `AND:    alu = data1_i & data2_i;
      `OR:     alu = data1_i | data2_i;
      default: alu = data1_i + data2_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      valid_o <= 1'b0;
      data_o  <= '0;
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else if (flush_i) begin
      state   <= IDLE;
      valid_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          valid_o <= 1'b0;
          if (accept && is_mul) begin
            mcand <= data1_i;
            mplr  <= data2_i;
            acc   <= '0;
            cnt   <= CW'(WIDTH);
            state <= BUSY;
          end else if (accept) begin
            data_o  <= alu;
            valid_o <= 1'b1;
          end
        end
        BUSY: begin
          acc   <= sum;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt - CW'(1);
          // last partial product is folded straight into the result
          if (cnt == CW'(1)) begin
            data_o  <= sum;
            valid_o <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          valid_o <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          valid_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer with directed
// corner cases (latency, flush, mid-multiply reset).
`ifndef ADD
`define ADD 3'b010
`endif
`ifndef SUB
`define SUB 3'b110
`endif
`ifndef AND
`define AND 3'b000
`endif
`ifndef OR
`define OR 3'b001
`endif
`ifndef MUL
`define MUL 3'b011
`endif

module tb_alu_sequencer;
  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic [2:0]   ALUCtrl_i;
  logic [W-1:0] data1_i;
  logic [W-1:0] data2_i;
  logic         flush_i;
  logic         stall_o;
  logic         valid_o;
  logic [W-1:0] data_o;

  alu_sequencer #(.WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ALUCtrl_i(ALUCtrl_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .valid_o  (valid_o),
    .data_o   (data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] d;
    int           c;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           vecs = 0;
  int           errs = 0;
  bit           mon_en = 0;
  bit           exp_stall = 0;
  logic [W-1:0] last_res = '0;

  always @(posedge clk_i) cyc++;

  function automatic logic [W-1:0] ref_model(logic [2:0] op,
                                             logic [W-1:0] a,
                                             logic [W-1:0] b);
    longint unsigned p;
    case (op)
      `SUB: return a - b;
      `AND: return a & b;
      `OR:  return a | b;
      `MUL: begin
        p = longint'(a) * longint'(b);
        return p[W-1:0];
      end
      default: return a + b;
    endcase
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is presented
  always @(negedge clk_i) begin
    if (mon_en) begin
      check("stall", {31'b0, stall_o}, {31'b0, exp_stall});
      if (valid_o === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", {31'b0, valid_o}, '0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("data", data_o, e.d);
          check("latency", W'(cyc), W'(e.c));
        end
      end else if (sb.size() > 0 && sb[0].c <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("missing_valid", {31'b0, valid_o}, 32'd1);
      end
    end
  end

  task automatic drive(bit v, logic [2:0] op, logic [W-1:0] a,
                       logic [W-1:0] b, bit fl, bit st);
    valid_i   = v;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    flush_i   = fl;
    exp_stall = st;
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    e.d = ref_model(op, a, b);
    last_res = e.d;
    if (op == `MUL) begin
      e.c = cyc + 1 + W;
      sb.push_back(e);
      for (int i = 0; i <= W + 1; i++)
        drive(1'b1, op, a, b, 1'b0, i <= W);
    end else begin
      e.c = cyc + 1;
      sb.push_back(e);
      drive(1'b1, op, a, b, 1'b0, 1'b0);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, `MUL, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    rst_i   = 1'b0;
    valid_i = 1'b0;
    ALUCtrl_i = `ADD;
    data1_i = '0;
    data2_i = '0;
    flush_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", {31'b0, valid_o}, '0);
    check("rst_data", data_o, '0);
    check("rst_stall", {31'b0, stall_o}, '0);
    rst_i  = 1'b1;
    mon_en = 1;

    issue(`ADD, 32'd5, 32'd3);
    issue(`SUB, 32'd3, 32'd5);
    idle(2);
    issue(`MUL, 32'd7, 32'd6);
    issue(`MUL, 32'hFFFF_FFFF, 32'd2);
    issue(`MUL, 32'h8000_0000, 32'h8000_0000);
    issue(`MUL, 32'd3, 32'd4);
    issue(`OR, 32'hF0, 32'h0F);
    idle(2);

    // Flush in the 10th busy cycle of a multiply
    for (int i = 0; i <= 10; i++)
      drive(1'b1, `MUL, 32'd9, 32'd9, i == 10, 1'b1);
    drive(1'b0, `ADD, '0, '0, 1'b0, 1'b0);
    check("flush_data_hold", data_o, last_res);
    check("flush_no_valid", {31'b0, valid_o}, '0);
    idle(3);

    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        drive(1'b1, op, a, b, 1'b1, 1'b0);
      end else if ($urandom_range(0, 5) == 0) begin
        drive(1'b0, op, a, b, 1'b0, 1'b0);
      end else if (op == `MUL && $urandom_range(0, 2) != 0) begin
        issue(`ADD, a, b);
      end else begin
        issue(op, a, b);
      end
    end
    idle(2);

    issue(`ADD, 32'd1, 32'd2);
    for (int i = 0; i <= 4; i++)
      drive(1'b1, `MUL, 32'd3, 32'd4, 1'b0, 1'b1);
    mon_en  = 0;
    sb.delete();
    valid_i = 1'b0;
    rst_i   = 1'b0;
    #1;
    check("midrst_valid", {31'b0, valid_o}, '0);
    check("midrst_data", data_o, '0);
    check("midrst_stall", {31'b0, stall_o}, '0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    exp_stall = 0;
    @(negedge clk_i);
    mon_en = 1;
    @(posedge clk_i);
    #1;
    issue(`ADD, 32'd1, 32'd1);
    idle(3);

    if (sb.size() != 0)
      check("leftover", W'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: no finish by time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle execution controller for the EX stage of the RISC-V pipeline. It takes the ALU control code and the two operands presented to EX and decides how they are executed. ADD/SUB/AND/OR complete in one registered cycle. MUL is run on an internal iterative shift-add multiplier, and the block asserts a stall to the hazard unit until the product is ready. It sits between the ALU control decode and the EX/MEM pipeline register, and replaces the single-cycle MUL path.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  reset, asynchronous, active-low; forces every register below to its reset value immediately.
- valid_i  in  1  an instruction is present in EX with ALUCtrl_i, data1_i and data2_i valid.
- ALUCtrl_i  in  3  operation code, using the codebase encodings `ADD, `SUB, `MUL, `OR, `AND.
- data1_i  in  WIDTH  operand rs1.
- data2_i  in  WIDTH  operand rs2 or immediate.
- flush_i  in  1  synchronous abort of the current instruction, from branch/hazard logic.
- stall_o  out  1  combinational; hold PC, IF/ID and ID/EX while high.
- valid_o  out  1  registered; data_o holds a completed result this cycle.
- data_o  out  WIDTH  registered result.

## Operation
State machine with three states: IDLE, BUSY, DONE.

IDLE:
- The block accepts an instruction when valid_i=1 and flush_i=0.
- For a non-MUL code, the result is registered into data_o at the next edge with valid_o=1, and the state stays IDLE.
  - `ADD: data1+data2.
  - `SUB: data1-data2.
  - `AND: data1&data2.
  - `OR: data1|data2.
  - Any other code is executed as `ADD.
- For `MUL, the block latches the multiplicand (data1), the multiplier (data2) and acc=0, loads cnt=WIDTH, clears valid_o, and moves to BUSY.

BUSY:
- Each cycle: if the multiplier LSB is 1, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, cnt -= 1.
- When cnt reaches 1 on the current edge, the block writes the final acc into data_o, sets valid_o=1, and moves to DONE.

DONE:
- valid_o=1 and stall_o=0 for one cycle.
- valid_i is ignored, because the stalled MUL is still held in ID/EX.
- Next state is IDLE with valid_o=0. The pipeline advances on this edge.

Outside those cases valid_o=0 and data_o holds its last value.

stall_o = (state==IDLE & valid_i & ALUCtrl_i==`MUL & ~flush_i) | (state==BUSY).

Arithmetic:
- All results are modulo 2^WIDTH. Add and subtract wrap with no flag.
- MUL returns the low WIDTH bits of the unsigned product. This equals the signed low half.
- The accumulator is WIDTH bits; carries out of the top bit are discarded.
- cnt is $clog2(WIDTH+1) bits.

flush_i:
- Highest priority after reset. In any state it forces IDLE and valid_o=0 at the next edge, with no result.
- flush_i in the same cycle as valid_i means the instruction is not accepted and stall_o=0.

Reset values: state=IDLE, valid_o=0, data_o=0, acc=0, cnt=0, latched operands=0. stall_o=0 unless the IDLE accept term holds.

## Timing
- Non-MUL latency: 1 cycle, from the accept edge to valid_o. A new instruction can be accepted every cycle.
- MUL:
  - Accepted at edge E0.
  - stall_o is high in the cycle before E0 and through BUSY.
  - valid_o=1 in the cycle after edge E0+WIDTH, which is the DONE state.
  - Total latency is WIDTH+1 cycles; 33 for WIDTH=32.
  - Latency is fixed: there is no early termination for small multipliers.
- Back-to-back operations:
  - After DONE, the next instruction is accepted in the following IDLE cycle.
  - The earliest non-MUL result after a MUL appears 2 cycles after the MUL's valid_o.
- Reset mid-multiply: outputs go to their reset values immediately. After release the block is in IDLE and the partial product is lost.

## Test plan
- Reset release, then `ADD with 5,3, then `SUB with 3,5 on consecutive cycles -> valid_o high for 2 consecutive cycles with data_o 8 then 0xFFFFFFFE. stall_o stays 0 throughout.
- `MUL with 7,6 -> stall_o high for 33 cycles including the accept cycle. valid_o=1 with data_o=42 exactly 33 edges after accept, then stall_o=0.
- `MUL with 0xFFFFFFFF,2 -> data_o=0xFFFFFFFE. `MUL with 0x80000000,0x80000000 -> data_o=0.
- `MUL with 9,9, flush_i pulsed in the 10th BUSY cycle -> state IDLE next edge, stall_o=0, valid_o never asserted, data_o unchanged.
- rst_i dropped in the 5th BUSY cycle of `MUL 3,4 -> valid_o=0 and data_o=0 immediately. After release, `ADD 1,1 -> data_o=2 one cycle later.
- `MUL 3,4 with valid_i held through DONE, then `OR with 0xF0,0x0F -> only one product, 12, is reported. 0xFF follows 2 cycles later.
